// File: rtl/tb_memory_regbus_mp.sv
// Multi-port regbus memory model: NumPorts masters share one word array behind a
// round-robin arbiter, with programmable response latency, byte strobes and range errors.
package tb_memory_regbus_mp_pkg;
  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } rsp_t;
endpackage

module tb_memory_regbus_mp #(
  parameter int unsigned          NumPorts  = 2,
  parameter int unsigned          AddrWidth = 48,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          NumWords  = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0,
  parameter int unsigned          Latency   = 1,
  parameter type                  req_t     = tb_memory_regbus_mp_pkg::req_t,
  parameter type                  rsp_t     = tb_memory_regbus_mp_pkg::rsp_t,
  localparam int unsigned         IdxW      = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  req_t            req_i [NumPorts],
  output rsp_t            rsp_o [NumPorts],
  output logic            busy_o,
  output logic [IdxW-1:0] grant_idx_o
);

  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned WordW = (NumWords > 1) ? $clog2(NumWords) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e               r_state, w_state_nxt;
  logic [IdxW-1:0]      r_ptr, r_grant, w_sel;
  logic                 w_any;
  logic [3:0]           r_cnt;
  logic                 r_write;
  logic [DataWidth-1:0] r_wdata;
  logic [StrbW-1:0]     r_wstrb;
  logic [WordW-1:0]     r_idx;
  logic                 r_oob;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_error;
  logic [DataWidth-1:0] r_mem [NumWords];

  logic [AddrWidth-1:0] w_sel_addr, w_off, w_word;
  logic                 w_sel_oob, w_cur_oob;
  logic [WordW-1:0]     w_sel_idx, w_cur_idx;

  // Scan offsets from high to low so the first valid port at or after r_ptr wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_any = 1'b0;
    w_sel = r_ptr;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      if (req_i[(int'(r_ptr) + k) % NumPorts].valid) begin
        w_any = 1'b1;
        w_sel = IdxW'((int'(r_ptr) + k) % NumPorts);
      end
    end
  end

  always_comb begin
    w_sel_addr = req_i[w_sel].addr;
    w_off      = w_sel_addr - BaseAddr;
    w_word     = w_off >> OffW;
    w_sel_oob  = (w_sel_addr < BaseAddr) || (w_word >= AddrWidth'(NumWords));
    w_sel_idx  = WordW'(w_word);
  end

  // With Latency=1 the grant cycle feeds RESP directly, so decode the live request.
  assign w_cur_idx = (r_state == ST_IDLE) ? w_sel_idx : r_idx;
  assign w_cur_oob = (r_state == ST_IDLE) ? w_sel_oob : r_oob;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = (Latency <= 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt <= 4'd1) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_idx   <= '0;
      r_oob   <= 1'b0;
      r_rdata <= '0;
      r_error <= 1'b0;
      // NOTE: the array is a harness model that must come up all-zero, so it is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < NumWords; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_sel;
            r_cnt   <= 4'(Latency - 1);
            r_write <= req_i[w_sel].write;
            r_wdata <= req_i[w_sel].wdata;
            r_wstrb <= req_i[w_sel].wstrb;
            r_idx   <= w_sel_idx;
            r_oob   <= w_sel_oob;
          end
        end
        ST_WAIT: r_cnt <= r_cnt - 4'd1;
        ST_RESP: begin
          r_ptr <= (int'(r_grant) == NumPorts - 1) ? '0 : r_grant + 1'b1;
          if (r_write && !r_oob) begin
            for (int b = 0; b < StrbW; b++) begin
              if (r_wstrb[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
          end
        end
        default: ;
      endcase
      // Capture read data on entry to RESP, i.e. before that cycle's write commits.
      if (w_state_nxt == ST_RESP) begin
        r_rdata <= w_cur_oob ? '0 : r_mem[w_cur_idx];
        r_error <= w_cur_oob;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      rsp_o[i] = '0;
      if ((r_state == ST_RESP) && (int'(r_grant) == i)) begin
        rsp_o[i].ready = 1'b1;
        rsp_o[i].rdata = r_rdata;
        rsp_o[i].error = r_error;
      end
    end
  end

  assign busy_o      = (r_state != ST_IDLE);
  assign grant_idx_o = r_grant;

endmodule

// File: tb/tb_tb_memory_regbus_mp.sv
// Self-checking bench for tb_memory_regbus_mp: three instances (Latency 1/4/8),
// directed vectors, multi-cycle corner sequences and a randomized model comparison.
module tb_tb_memory_regbus_mp;
  import tb_memory_regbus_mp_pkg::*;

  localparam int          NW   = 16;
  localparam logic [47:0] BASE = 48'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  req_t rq [3][3];
  rsp_t rs [3][3];
  req_t req_a [2], req_b [3], req_c [2];
  rsp_t rsp_a [2], rsp_b [3], rsp_c [2];
  logic busy_a, busy_b, busy_c;
  logic gidx_a, gidx_c;
  logic [1:0] gidx_b;
  logic busy_v [3];
  logic [1:0] gidx_v [3];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem_m [3][NW];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      req_a[p] = rq[0][p];
      req_c[p] = rq[2][p];
    end
    for (int p = 0; p < 3; p++) req_b[p] = rq[1][p];
  end

  always_comb begin
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < 3; p++) rs[d][p] = '0;
    for (int p = 0; p < 2; p++) begin
      rs[0][p] = rsp_a[p];
      rs[2][p] = rsp_c[p];
    end
    for (int p = 0; p < 3; p++) rs[1][p] = rsp_b[p];
  end

  assign busy_v[0] = busy_a;
  assign busy_v[1] = busy_b;
  assign busy_v[2] = busy_c;
  assign gidx_v[0] = {1'b0, gidx_a};
  assign gidx_v[1] = gidx_b;
  assign gidx_v[2] = {1'b0, gidx_c};

  tb_memory_regbus_mp #(.NumPorts(2), .AddrWidth(48), .DataWidth(32), .NumWords(NW),
    .BaseAddr(BASE), .Latency(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .rsp_o(rsp_a), .busy_o(busy_a), .grant_idx_o(gidx_a));

  tb_memory_regbus_mp #(.NumPorts(3), .AddrWidth(48), .DataWidth(32), .NumWords(NW),
    .BaseAddr(BASE), .Latency(4)) u_l4 (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .rsp_o(rsp_b), .busy_o(busy_b), .grant_idx_o(gidx_b));

  tb_memory_regbus_mp #(.NumPorts(2), .AddrWidth(48), .DataWidth(32), .NumWords(NW),
    .BaseAddr(BASE), .Latency(8)) u_l8 (
    .clk_i(clk), .rst_i(rst), .req_i(req_c), .rsp_o(rsp_c), .busy_o(busy_c), .grant_idx_o(gidx_c));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 8);
  endfunction

  function automatic int np_of(input int d);
    return (d == 1) ? 3 : 2;
  endfunction

  function automatic bit in_rng(input logic [47:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < NW);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < NW; w++) mem_m[d][w] = '0;
  endtask

  task automatic model_write(input int d, input int w, input logic [31:0] wd, input logic [3:0] ws);
    for (int b = 0; b < 4; b++)
      if (ws[b]) mem_m[d][w][8*b +: 8] = wd[8*b +: 8];
  endtask

  // Present one request, wait for ready (bounded), then step past the RESP cycle.
  task automatic do_txn(input int d, input int p, input logic wr, input logic [47:0] a,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    rq[d][p].addr  = a;
    rq[d][p].write = wr;
    rq[d][p].wdata = wd;
    rq[d][p].wstrb = ws;
    rq[d][p].valid = 1'b1;
    lat = 999;
    rd  = '0;
    er  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rs[d][p].ready) begin
        lat = k;
        rd  = rs[d][p].rdata;
        er  = rs[d][p].error;
        break;
      end
    end
    rq[d][p].valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic check_txn(input int d, input int p, input logic wr, input logic [47:0] a,
                           input logic [31:0] wd, input logic [3:0] ws, input string tag);
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          oob;
    int          w;
    oob = !in_rng(a);
    w   = oob ? 0 : int'((a - BASE) / 4);
    do_txn(d, p, wr, a, wd, ws, rd, er, lat);
    check({tag, "_lat"}, lat, lat_of(d));
    check({tag, "_err"}, er, oob);
    if (!wr) check({tag, "_rdata"}, rd, oob ? 32'h0 : mem_m[d][w]);
    if (wr && !oob) model_write(d, w, wd, ws);
  endtask

  // All three ports of the Latency=4 instance request at once; expect pointer order.
  task automatic arb_round(input int first, input string tag);
    int order [$];
    int rdy_k [$];
    int busy_hi;
    busy_hi = 0;
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      rq[1][p].addr  = BASE + 48'(4 * p);
      rq[1][p].write = 1'b0;
      rq[1][p].wdata = '0;
      rq[1][p].wstrb = '0;
      rq[1][p].valid = 1'b1;
    end
    for (int k = 1; k <= 30 && order.size() < 3; k++) begin
      @(posedge clk); #1;
      if (busy_v[1]) busy_hi++;
      for (int p = 0; p < 3; p++) begin
        if (rs[1][p].ready) begin
          order.push_back(p);
          rdy_k.push_back(k);
          check($sformatf("%s_gidx%0d", tag, p), gidx_v[1], p);
          rq[1][p].valid = 1'b0;
        end
      end
    end
    for (int p = 0; p < 3; p++) rq[1][p].valid = 1'b0;
    @(posedge clk);
    check({tag, "_count"}, order.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_order%0d", tag, i), (i < order.size()) ? order[i] : 99, (first + i) % 3);
      check($sformatf("%s_rdycyc%0d", tag, i), (i < rdy_k.size()) ? rdy_k[i] : 99, 4 + 5 * i);
    end
    check({tag, "_busy_cycles"}, busy_hi, 12);
  endtask

  typedef struct {
    int          d;
    int          p;
    bit          wr;
    logic [47:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] rd;
    bit          er;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nrdy;

    for (int d = 0; d < 3; d++)
      for (int p = 0; p < 3; p++) rq[d][p] = '0;
    clear_model();

    tbl[0]  = '{0, 0, 1'b1, 48'h110, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{0, 1, 1'b0, 48'h110, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{0, 0, 1'b1, 48'h114, 32'h11223344, 4'h5, 32'h0,        1'b0};
    tbl[3]  = '{0, 0, 1'b0, 48'h114, 32'h0,        4'h0, 32'h00220044, 1'b0};
    tbl[4]  = '{0, 1, 1'b0, 48'h140, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[5]  = '{0, 0, 1'b1, 48'h0FC, 32'h12345678, 4'hF, 32'h0,        1'b1};
    tbl[6]  = '{0, 0, 1'b0, 48'h100, 32'h0,        4'h0, 32'h0,        1'b0};
    tbl[7]  = '{0, 1, 1'b1, 48'h110, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    tbl[8]  = '{0, 1, 1'b0, 48'h113, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[9]  = '{1, 2, 1'b1, 48'h13C, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    tbl[10] = '{1, 1, 1'b0, 48'h13C, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
    tbl[11] = '{2, 1, 1'b1, 48'h104, 32'h0BADCAFE, 4'hC, 32'h0,        1'b0};
    tbl[12] = '{2, 0, 1'b0, 48'h104, 32'h0,        4'h0, 32'h0BAD0000, 1'b0};
    tbl[13] = '{0, 1, 1'b0, 48'h0FF, 32'h0,        4'h0, 32'h0,        1'b1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {busy_a, busy_b, busy_c}, 3'b000);
    check("rst_gidx", {gidx_a, gidx_b, gidx_c}, 4'h0);
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < np_of(d); p++)
        check($sformatf("rst_rsp_d%0d_p%0d", d, p), rs[d][p], '0);
    @(negedge clk);
    rst = 1'b0;

    arb_round(0, "arb1");
    check_txn(1, 0, 1'b0, BASE, 32'h0, 4'h0, "arb_ptr_adv");
    arb_round(1, "arb2");

    for (int i = 0; i < NVEC; i++) begin
      do_txn(tbl[i].d, tbl[i].p, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].ws, rd, er, lat);
      check($sformatf("vec%0d_lat", i), lat, lat_of(tbl[i].d));
      check($sformatf("vec%0d_err", i), er, tbl[i].er);
      if (!tbl[i].wr) check($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      if (tbl[i].wr && !tbl[i].er)
        model_write(tbl[i].d, int'((tbl[i].a - BASE) / 4), tbl[i].wd, tbl[i].ws);
    end

    for (int n = 0; n < 60; n++) begin
      int          d, p;
      logic [47:0] a;
      d = $urandom_range(0, 2);
      p = $urandom_range(0, np_of(d) - 1);
      a = BASE - 48'd8 + 48'($urandom_range(0, (NW + 4) * 4 - 1));
      check_txn(d, p, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $sformatf("rnd%0d", n));
    end

    // Master drops valid right after the grant; the write must still complete.
    @(negedge clk);
    rq[2][0].addr  = BASE + 48'h8;
    rq[2][0].write = 1'b1;
    rq[2][0].wdata = 32'h13579BDF;
    rq[2][0].wstrb = 4'hF;
    rq[2][0].valid = 1'b1;
    @(posedge clk); #1;
    check("drop_busy", busy_v[2], 1'b1);
    rq[2][0].valid = 1'b0;
    lat = 999;
    for (int k = 2; k <= 30; k++) begin
      @(posedge clk); #1;
      if (rs[2][0].ready) begin
        lat = k;
        break;
      end
    end
    @(posedge clk);
    check("drop_lat", lat, 8);
    model_write(2, 2, 32'h13579BDF, 4'hF);
    check_txn(2, 1, 1'b0, BASE + 48'h8, 32'h0, 4'h0, "drop_rd");

    // Reset three cycles into a Latency=8 write: no ready, nothing committed.
    @(negedge clk);
    rq[2][1].addr  = BASE + 48'h20;
    rq[2][1].write = 1'b1;
    rq[2][1].wdata = 32'hCAFEF00D;
    rq[2][1].wstrb = 4'hF;
    rq[2][1].valid = 1'b1;
    nrdy = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (rs[2][1].ready) nrdy++;
      if (k == 3) begin
        check("rstmid_pre_busy", busy_v[2], 1'b1);
        check("rstmid_pre_gidx", gidx_v[2], 1);
        rst = 1'b1;
        #1;
        check("rstmid_busy", {busy_a, busy_b, busy_c}, 3'b000);
        check("rstmid_gidx", gidx_v[2], 0);
        for (int p = 0; p < 2; p++) check($sformatf("rstmid_rsp%0d", p), rs[2][p], '0);
      end
      if (k == 5) rq[2][1].valid = 1'b0;
      if (k == 6) rst = 1'b0;
    end
    check("rstmid_no_ready", nrdy, 0);
    clear_model();
    check_txn(2, 1, 1'b0, BASE + 48'h20, 32'h0, 4'h0, "rstmid_rd");
    check_txn(0, 0, 1'b0, BASE + 48'h10, 32'h0, 4'h0, "rst_clears_l1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
